// File: rtl/pmu_i2c_byte_master.sv
// Byte-level open-drain I2C master stepped one byte at a time by the PMU bus-interface controller.
// Each bus phase lasts CLK_DIV clocks; with no stretching, start->first data_latch is 2*CLK_DIV and bytes are 36*CLK_DIV apart.
// Slave clock stretching freezes the quarter counter while a released SCL still reads low (ALLOW_STRETCH=1).
module pmu_i2c_byte_master #(
  parameter int CLK_DIV       = 16,
  parameter bit ALLOW_STRETCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        scl,
  inout  wire        sda,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       done,
  input  logic       rw,
  output logic       data_latch,
  output logic       ready,
  output logic       failed,
  output logic [7:0] in_data,
  output logic       in_data_valid,
  input  logic       clear_failed
);

  typedef enum logic [3:0] {
    IDLE, START_A, START_B,
    BIT0, BIT1, BIT2, BIT3,
    ACK0, ACK1, ACK2, ACK3,
    STOP_A, STOP_B, STOP_C
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       is_wr;
  logic       scl_low, sda_low;
  logic       scl_in, sda_in;
  logic       stall, tick, nack_set;

  // Open-drain pins: only ever pull low, otherwise leave the line to the pull-up.
  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign scl_in = scl;
  assign sda_in = sda;

  // A released SCL that still reads low means a slave is stretching the clock.
  assign stall    = ALLOW_STRETCH && !scl_low && !scl_in;
  assign tick     = !stall && (cnt == LAST_CNT);
  assign nack_set = tick && (state == ACK2) && is_wr && sda_in;

  // Quarter-period counter; parked at zero in IDLE so START_A gets a full quarter.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || stall || tick) cnt <= '0;
    else                                         cnt <= cnt + 8'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE reacts to start at once, every other phase advances on the quarter tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = START_A;
      START_A: if (tick) state_nxt = START_B;
      START_B: if (tick) state_nxt = BIT0;
      BIT0:    if (tick) state_nxt = BIT1;
      BIT1:    if (tick) state_nxt = BIT2;
      BIT2:    if (tick) state_nxt = BIT3;
      BIT3:    if (tick) state_nxt = (bit_idx == 3'd7) ? ACK0 : BIT0;
      ACK0:    if (tick) state_nxt = ACK1;
      ACK1:    if (tick) state_nxt = ACK2;
      ACK2:    if (tick) state_nxt = ACK3;
      ACK3:    if (tick) state_nxt = done ? STOP_A : BIT0;
      STOP_A:  if (tick) state_nxt = STOP_B;
      STOP_B:  if (tick) state_nxt = STOP_C;
      STOP_C:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin drives, ready and the byte-boundary data_latch strobe decoded from the phase.
  always_comb begin
    scl_low    = 1'b0;
    sda_low    = 1'b0;
    ready      = 1'b0;
    data_latch = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      START_A: sda_low = 1'b1;
      START_B: begin
        scl_low    = 1'b1;
        sda_low    = 1'b1;
        data_latch = tick;
      end
      BIT0, BIT1: begin
        scl_low = 1'b1;
        sda_low = is_wr && !shift[7];
      end
      BIT2, BIT3: sda_low = is_wr && !shift[7];
      ACK0, ACK1: scl_low = 1'b1;
      ACK3:    data_latch = tick && !done;
      STOP_A: begin
        scl_low = 1'b1;
        sda_low = 1'b1;
      end
      STOP_B:  sda_low = 1'b1;
      default: ;
    endcase
  end

  // Datapath: byte load, MSB-first shifting, read-data capture and the sticky NACK flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift         <= '0;
      bit_idx       <= '0;
      is_wr         <= 1'b0;
      in_data       <= '0;
      in_data_valid <= 1'b0;
      failed        <= 1'b0;
    end else begin
      in_data_valid <= 1'b0;
      if (data_latch) begin
        shift   <= data;
        is_wr   <= rw;
        bit_idx <= '0;
      end
      // Reads sample while SCL is high; writes advance only after the high phase ends.
      if (tick && state == BIT2 && !is_wr) shift <= {shift[6:0], sda_in};
      if (tick && state == BIT3) begin
        if (is_wr) shift <= {shift[6:0], 1'b0};
        bit_idx <= bit_idx + 3'd1;
      end
      if (tick && state == ACK3 && !is_wr) begin
        in_data       <= shift;
        in_data_valid <= 1'b1;
      end
      // A NACK in the same cycle as clear_failed must still leave the flag set.
      if (nack_set)          failed <= 1'b1;
      else if (clear_failed) failed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmu_i2c_byte_master.sv
// Bench for pmu_i2c_byte_master: protocol-level I2C slave model plus directed and random transactions.
// A second instance with ALLOW_STRETCH=0 shares all controller inputs to compare stretch behaviour.
// Expected values come from I2C protocol rules and the quarter/byte timing arithmetic.
module tb_pmu_i2c_byte_master;
  localparam int DIV  = 4;
  localparam int BYTE = 36 * DIV;

  logic       clk = 1'b0;
  logic       reset, start, done, rw, clear_failed;
  logic [7:0] data;
  wire        scl, sda, scl2, sda2;
  logic       data_latch, ready, failed, in_data_valid;
  logic [7:0] in_data;
  logic       ns_latch, ns_ready, ns_failed, ns_valid;
  logic [7:0] ns_in_data;

  logic s_sda_low   = 1'b0;
  logic stretch_low = 1'b0;

  pullup (scl);
  pullup (sda);
  pullup (scl2);
  pullup (sda2);
  assign sda  = s_sda_low   ? 1'b0 : 1'bz;
  assign scl  = stretch_low ? 1'b0 : 1'bz;
  assign scl2 = stretch_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  pmu_i2c_byte_master #(.CLK_DIV(DIV), .ALLOW_STRETCH(1'b1)) u_dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .data(data), .start(start),
    .done(done), .rw(rw), .data_latch(data_latch), .ready(ready), .failed(failed),
    .in_data(in_data), .in_data_valid(in_data_valid), .clear_failed(clear_failed));

  pmu_i2c_byte_master #(.CLK_DIV(DIV), .ALLOW_STRETCH(1'b0)) u_ns (
    .clk(clk), .reset(reset), .scl(scl2), .sda(sda2), .data(data), .start(start),
    .done(done), .rw(rw), .data_latch(ns_latch), .ready(ns_ready), .failed(ns_failed),
    .in_data(ns_in_data), .in_data_valid(ns_valid), .clear_failed(clear_failed));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- protocol-level slave model (address LSB selects slave-transmit) ----------------
  logic [7:0] rx_sh = '0, tx_sh = '0, tx_byte = '0;
  logic [7:0] rx_q[$];
  int   bitcnt = 0, byte_idx = 0, n_start = 0, n_stop = 0, stop_cyc = 0, idle_gap = 0;
  bit   rd_mode = 0, tx_stop = 0, nack_mode = 0, master_ack = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk) begin
    if (prev_scl && scl && prev_sda && !sda) begin
      n_start++; idle_gap = cyc - stop_cyc;
      bitcnt = 0; byte_idx = 0; rd_mode = 0; tx_stop = 0; s_sda_low = 1'b0;
      rx_q.delete();
    end else if (prev_scl && scl && !prev_sda && sda) begin
      n_stop++; stop_cyc = cyc; s_sda_low = 1'b0;
    end else if (!prev_scl && scl) begin
      if (bitcnt < 8) begin
        rx_sh = {rx_sh[6:0], sda}; bitcnt++;
      end else if (bitcnt == 8) begin
        if (rd_mode && byte_idx > 0) begin
          master_ack = sda;
          if (sda) tx_stop = 1;
        end
        bitcnt = 9;
      end
    end else if (prev_scl && !scl) begin
      if (bitcnt == 8) begin
        if (rd_mode && byte_idx > 0) s_sda_low = 1'b0;
        else begin
          rx_q.push_back(rx_sh);
          if (byte_idx == 0) rd_mode = rx_sh[0];
          s_sda_low = !nack_mode;
        end
      end else if (bitcnt == 9) begin
        bitcnt = 0; byte_idx++;
        if (rd_mode && !tx_stop) begin tx_sh = tx_byte; s_sda_low = !tx_sh[7]; end
        else s_sda_low = 1'b0;
      end else if (bitcnt >= 1 && bitcnt <= 7 && rd_mode && byte_idx > 0 && !tx_stop) begin
        s_sda_low = !tx_sh[7 - bitcnt];
      end
    end
    prev_scl = scl; prev_sda = sda;
  end

  // Read-data strobe and no-stretch instance latch-spacing monitors.
  int n_valid = 0, valid_cyc = 0, ns_last = 0, ns_gap = 0;
  always @(negedge clk) begin
    if (in_data_valid) begin n_valid++; valid_cyc = cyc; end
    if (ns_latch) begin ns_gap = cyc - ns_last; ns_last = cyc; end
  end

  // ---------------- helpers ----------------
  logic [7:0] tb_bytes[8];
  bit         tb_rw[8];
  int         lat[8];
  int         t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_latch(output int t);
    t = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (data_latch) begin t = cyc; break; end
    end
    if (t < 0) check("latch_timeout", 0, 1);
  endtask

  task automatic wait_ready(input bit hold_start);
    bit seen = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ready) begin seen = 1; break; end
    end
    if (!seen) check("ready_timeout", 0, 1);
    done = 1'b0;
    if (hold_start) start = 1'b1;
  endtask

  task automatic begin_txn();
    data = tb_bytes[0]; rw = tb_rw[0]; done = 1'b0; start = 1'b1; t0 = cyc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!ready) break;
    end
    start = 1'b0;
  endtask

  task automatic run_txn(input int n, input bit hold_start);
    begin_txn();
    for (int i = 0; i < n; i++) begin
      wait_latch(lat[i]);
      @(negedge clk);
      if (i < n - 1) begin data = tb_bytes[i+1]; rw = tb_rw[i+1]; end
      else done = 1'b1;
    end
    wait_ready(hold_start);
  endtask

  task automatic check_rx(input int n);
    check("rx_count", rx_q.size(), n);
    for (int i = 0; i < n; i++)
      check("rx_byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(tb_bytes[i]));
  endtask

  task automatic check_spacing(input int n);
    check("first_latch", lat[0] - t0, 2 * DIV);
    for (int i = 1; i < n; i++) check("latch_gap", lat[i] - lat[i-1], BYTE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, s0, p0, v0, l0, l1;
    reset = 1'b1; start = 1'b0; done = 1'b0; rw = 1'b0; clear_failed = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_failed", failed, 0);
    check("rst_in_data", in_data, 0);
    check("rst_latch", data_latch, 0);
    check("rst_valid", in_data_valid, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);

    // Three-byte write with an ACKing slave.
    tb_bytes[0] = 8'h68; tb_bytes[1] = 8'h20; tb_bytes[2] = 8'h55;
    tb_rw[0] = 1; tb_rw[1] = 1; tb_rw[2] = 1;
    s0 = n_start; p0 = n_stop;
    run_txn(3, 0);
    check_spacing(3);
    check_rx(3);
    check("w3_start", n_start - s0, 1);
    check("w3_stop", n_stop - p0, 1);
    check("w3_failed", failed, 0);
    check("w3_ready", ready, 1);

    // Random write transactions.
    for (int r = 0; r < 3; r++) begin
      n = 2 + int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        tb_bytes[i] = 8'($urandom); tb_rw[i] = 1;
      end
      tb_bytes[0][0] = 1'b0;
      run_txn(n, 0);
      check_spacing(n);
      check_rx(n);
      check("rw_failed", failed, 0);
    end

    // NACKed address: STOP still issued, failed sticks in IDLE.
    nack_mode = 1; p0 = n_stop;
    tb_bytes[0] = 8'h68; tb_rw[0] = 1;
    run_txn(1, 0);
    check("nack_stop", n_stop - p0, 1);
    check("nack_failed", failed, 1);
    repeat (10) @(negedge clk);
    check("nack_hold", failed, 1);
    clear_failed = 1'b1; @(negedge clk); clear_failed = 1'b0;
    check("nack_clear", failed, 0);

    // clear_failed in exactly the cycle the NACK is sampled: set wins.
    begin_txn();
    wait_latch(l0);
    @(negedge clk); done = 1'b1;
    repeat (139) @(negedge clk);
    clear_failed = 1'b1; @(negedge clk); clear_failed = 1'b0;
    wait_ready(0);
    check("nack_vs_clear", failed, 1);
    nack_mode = 0;
    clear_failed = 1'b1; @(negedge clk); clear_failed = 1'b0;
    check("clear2", failed, 0);

    // Address write then one read byte: fixed 0xA5, then a random byte.
    for (int r = 0; r < 2; r++) begin
      tx_byte = (r == 0) ? 8'hA5 : 8'($urandom);
      tb_bytes[0] = 8'h69; tb_rw[0] = 1;
      tb_bytes[1] = 8'h00; tb_rw[1] = 0;
      v0 = n_valid;
      run_txn(2, 0);
      check("rd_data", in_data, tx_byte);
      check("rd_valid_cnt", n_valid - v0, 1);
      check("rd_valid_time", valid_cyc - lat[1], BYTE + 1);
      check("rd_master_nack", master_ack, 1);
      check_rx(1);
      repeat (20) @(negedge clk);
      check("rd_hold", in_data, tx_byte);
    end

    // Slave stretches SCL for 50 cycles during bit 3 of the first byte.
    tb_bytes[0] = 8'h68; tb_rw[0] = 1; tb_bytes[1] = 8'h3C; tb_rw[1] = 1;
    begin_txn();
    wait_latch(l0);
    @(negedge clk); data = tb_bytes[1]; rw = 1'b1;
    repeat (54) @(negedge clk);
    stretch_low = 1'b1;
    repeat (50) @(negedge clk);
    stretch_low = 1'b0;
    wait_latch(l1);
    check("stretch_gap", l1 - l0, BYTE + 48);
    check("nostretch_gap", ns_gap, BYTE);
    @(negedge clk); done = 1'b1;
    wait_ready(0);
    check_rx(2);
    check("stretch_failed", failed, 0);

    // Back-to-back: start raised in the first IDLE cycle after STOP.
    tb_bytes[0] = 8'h68; tb_rw[0] = 1; tb_bytes[1] = 8'h11; tb_rw[1] = 1;
    run_txn(2, 1);
    s0 = n_start;
    tb_bytes[1] = 8'($urandom);
    run_txn(2, 0);
    check("b2b_start", n_start - s0, 1);
    check("b2b_idle_ok", (idle_gap >= DIV) ? 1 : 0, 1);
    check_spacing(2);
    check_rx(2);

    // Reset during BIT2 of the first bit.
    tb_bytes[0] = 8'h68; tb_rw[0] = 1;
    begin_txn();
    wait_latch(l0);
    repeat (10) @(negedge clk);
    check("pre_rst_sda", sda, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_latch", data_latch, 0);
    check("mid_rst_in_data", in_data, 0);
    reset = 1'b0;
    @(negedge clk);
    tb_bytes[0] = 8'h5A; tb_bytes[1] = 8'($urandom); tb_rw[1] = 1;
    run_txn(2, 0);
    check_spacing(2);
    check_rx(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmu_i2c_byte_master.md
Name: pmu_i2c_byte_master

Overview:
Byte-level open-drain I2C master that sits directly downstream of the PMU bus-interface controller and drives the PMU SCL/SDA pins. The controller steps it through a transaction one byte at a time: start, then byte requests (write or single-byte read), then done. The block generates START/STOP, shifts bytes MSB-first, checks slave ACK, and returns read data.

Parameters:
CLK_DIV, 16, system clocks per SCL quarter-period (legal range 2..255).
ALLOW_STRETCH, 1, 1 = a released SCL must read high before timing continues (slave clock stretching).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
scl  inout  1  open-drain: drives 0 or z; sampled for stretching
sda  inout  1  open-drain: drives 0 or z; sampled for ACK and read data
data  input  8  byte to transmit; sampled on the data_latch cycle
start  input  1  level; starts a transaction while idle
done  input  1  level; at a byte boundary, 1 = issue STOP
rw  input  1  1 = write byte, 0 = read byte; sampled on the data_latch cycle
data_latch  output  1  one-cycle pulse; data/rw captured, byte begins
ready  output  1  1 = idle, bus released
failed  output  1  sticky; a write byte was NACKed
in_data  output  8  last byte read; held until the next read completes
in_data_valid  output  1  one-cycle pulse when in_data updates
clear_failed  input  1  clears failed

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: scl and sda released (z), ready=1, failed=0, in_data=0, data_latch=0, in_data_valid=0. Internal state returns to IDLE. Reset mid-transaction releases both lines immediately; no STOP is generated.
- Quarter tick: a counter counts 0..CLK_DIV-1. Each FSM phase lasts one quarter.
- Stretch: in any phase with SCL released and ALLOW_STRETCH=1, the counter holds at 0 while scl reads 0.
- FSM states: IDLE, START_A, START_B, BIT0, BIT1, BIT2, BIT3, ACK0, ACK1, ACK2, ACK3, STOP_A, STOP_B, STOP_C.
- IDLE: ready=1, both lines released. When start=1, go to START_A; ready drops the next cycle.
- START_A: SDA driven 0 while SCL is released.
- START_B: SCL driven 0. On the final cycle of START_B, pulse data_latch, load the shift register from data, capture rw, go to BIT0.
- Bit phases (8 bits, MSB first):
  - BIT0: SCL low; SDA set to the bit for a write, released for a read.
  - BIT1: SCL low.
  - BIT2: SCL released; on its last cycle, sample sda into the shift register (read).
  - BIT3: SCL high.
- ACK phases follow the same four-phase pattern:
  - Write: SDA released. The ACK is sampled at the end of ACK2. If sampled 1 (NACK), set failed.
  - Read: master drives NACK (SDA released). At the end of ACK3, in_data takes the shift register and in_data_valid pulses for 1 cycle.
- Byte boundary (last cycle of ACK3):
  - done=1: go to STOP_A.
  - done=0: pulse data_latch, load the next byte and rw, go to BIT0. There is no gap cycle.
- NACK does not abort the transaction. Bytes continue to clock out so the controller sequence always completes; failed reports the error.
- STOP_A: SCL low, SDA 0. STOP_B: SCL released. STOP_C: SDA released. Then IDLE with ready=1.
- To issue a new START after a STOP, start must be seen again in IDLE. No repeated-START is generated.
- failed:
  - Set on NACK; cleared only by clear_failed.
  - Set has priority when both occur in the same cycle.
  - failed is unaffected by start.
- Timing at ALLOW_STRETCH=0:
  - One bit or ACK = 4*CLK_DIV cycles; one byte slot = 36*CLK_DIV cycles.
  - start (seen in IDLE) to first data_latch = 2*CLK_DIV cycles.
  - data_latch pulses are exactly 36*CLK_DIV apart.
- data/rw are don't-care except on data_latch cycles. done and start are don't-care except at the points above.

Test Plan:
- CLK_DIV=4, ACKing slave model; write 0x68, 0x20, 0x55 with done raised after the third latch → 3 data_latch pulses 144 cycles apart; slave sees START, the three bytes, STOP; failed=0; ready returns to 1.
- Slave NACKs address 0x68, done raised after the first latch → STOP issued, failed=1 held in IDLE. Pulse clear_failed → failed=0. With clear_failed coincident with a NACK → failed stays 1.
- Write 0x69 then read (rw=0) with slave returning 0xA5 → at ACK3 end, in_data=0xA5 with a 1-cycle in_data_valid; master releases SDA on the 9th clock (NACK); in_data holds 0xA5 afterwards.
- Slave holds SCL low 50 cycles in bit 3 of a write → timing resumes after release. With ALLOW_STRETCH=0 → no wait, 144-cycle byte spacing unchanged.
- Back-to-back transactions: start re-asserted the cycle ready rises → new START begins; bus idle time ≥ 1 quarter.
- reset asserted during BIT2 → next cycle scl=z, sda=z, ready=1, data_latch=0; a following transaction proceeds normally.
